// File: rtl/dense_seq_pkg.sv
// Shared definitions for the dense-layer sequencer: FSM state encoding and
// address/latency helper functions.
package dense_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BIAS  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int DEF_W       = 96;
  localparam int DEF_H       = 96;
  localparam int DEF_NEURONS = 256;
  localparam int DEF_MEM_LAT = 1;
  localparam int DEF_MUL_LAT = 1;

  // Address width for a space of n entries; never below one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cycles from a read strobe to its product reaching the accumulator.
  function automatic int lat_sum(input int mem_lat, input int mul_lat);
    return mem_lat + mul_lat;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Synchronous-reset shift register; out_o is in_i delayed by exactly DEPTH cycles.
// DEPTH must be at least 1.
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb sr_d = in_i;
    end else begin : g_shift
      always_comb sr_d = {sr_q[DEPTH-2:0], in_i};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: sequencer for a time-multiplexed dense layer (one shared multiplier
// feeding an accumulator). Optional macro DENSE_SEQ_CTRL_STALL_EN adds stall_i backpressure.
module dense_seq_ctrl
  import dense_seq_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int H       = DEF_H,
  parameter int NEURONS = DEF_NEURONS,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  localparam int N_IN   = W * H,
  localparam int DAW    = addr_w(N_IN),
  localparam int KAW    = addr_w(N_IN * NEURONS),
  localparam int NAW    = addr_w(NEURONS)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef DENSE_SEQ_CTRL_STALL_EN
  input  logic           stall_i,
`endif
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           rd_en_o,
  output logic [DAW-1:0] data_addr_o,
  output logic [KAW-1:0] kern_addr_o,
  output logic [NAW-1:0] bias_addr_o,
  output logic           acc_clr_o,
  output logic           mac_valid_o,
  output logic           bias_sel_o,
  output logic           wr_en_o,
  output logic [NAW-1:0] wr_addr_o
);

  localparam int L   = lat_sum(MEM_LAT, MUL_LAT);
  localparam int DCW = addr_w(L);

  state_e         state_q, state_d;
  logic [DAW-1:0] idx_q, idx_d;
  logic [NAW-1:0] neuron_q, neuron_d;
  logic [KAW-1:0] kern_q, kern_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           rd_en_q, rd_en_d;
  logic           acc_clr_q, acc_clr_d;
  logic           bias_sel_q, bias_sel_d;
  logic           wr_en_q, wr_en_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           stall;

`ifdef DENSE_SEQ_CTRL_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Next-state and counter update; the kernel address runs continuously
  // across neurons because neuron*N_IN + idx is just a running count.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    neuron_d = neuron_q;
    kern_d   = kern_q;
    drain_d  = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_LOAD;
          idx_d    = '0;
          neuron_d = '0;
          kern_d   = '0;
        end
      end
      ST_LOAD: begin
        if (!stall) begin
          if (idx_q == DAW'(N_IN - 1)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            idx_d  = idx_q + DAW'(1);
            kern_d = kern_q + KAW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCW'(L - 1)) begin
          state_d = ST_BIAS;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      ST_BIAS: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (neuron_q == NAW'(NEURONS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_LOAD;
          neuron_d = neuron_q + NAW'(1);
          idx_d    = '0;
          kern_d   = kern_q + KAW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are registered from the state being entered so they line up
    // with the addresses presented in that same cycle.
    rd_en_d    = (state_d == ST_LOAD);
    acc_clr_d  = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    bias_sel_d = (state_d == ST_BIAS);
    wr_en_d    = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_DRAIN) ||
                 (state_d == ST_BIAS) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      neuron_q   <= '0;
      kern_q     <= '0;
      drain_q    <= '0;
      rd_en_q    <= 1'b0;
      acc_clr_q  <= 1'b0;
      bias_sel_q <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      neuron_q   <= neuron_d;
      kern_q     <= kern_d;
      drain_q    <= drain_d;
      rd_en_q    <= rd_en_d;
      acc_clr_q  <= acc_clr_d;
      bias_sel_q <= bias_sel_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // A stalled cycle suppresses the strobe; the delay line still shifts so the
  // gap reappears on mac_valid_o L cycles later.
  assign rd_en_o = rd_en_q & ~stall;

  valid_delay #(
    .DEPTH(L)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .in_i (rd_en_o),
    .out_o(mac_valid_o)
  );

  assign data_addr_o = idx_q;
  assign kern_addr_o = kern_q;
  assign bias_addr_o = neuron_q;
  assign wr_addr_o   = neuron_q;
  assign acc_clr_o   = acc_clr_q;
  assign bias_sel_o  = bias_sel_q;
  assign wr_en_o     = wr_en_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Scoreboard bench for dense_seq_ctrl: a layer-level timing model pushes expected
// strobe events on each accepted start; a negedge monitor pops and compares them.
module tb_dense_seq_ctrl;

  localparam int W       = 2;
  localparam int H       = 2;
  localparam int NEURONS = 3;
  localparam int MEM_LAT = 1;
  localparam int MUL_LAT = 1;
  localparam int N_IN    = W * H;
  localparam int L       = MEM_LAT + MUL_LAT;
  localparam int P       = N_IN + L + 2;
  localparam int DAW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KAW     = (N_IN * NEURONS > 1) ? $clog2(N_IN * NEURONS) : 1;
  localparam int NAW     = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           busy_o, done_o, rd_en_o, acc_clr_o, mac_valid_o, bias_sel_o, wr_en_o;
  logic [DAW-1:0] data_addr_o;
  logic [KAW-1:0] kern_addr_o;
  logic [NAW-1:0] bias_addr_o, wr_addr_o;
`ifdef DENSE_SEQ_CTRL_STALL_EN
  logic           stall_i;
`endif

  dense_seq_ctrl #(
    .W(W), .H(H), .NEURONS(NEURONS), .MEM_LAT(MEM_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef DENSE_SEQ_CTRL_STALL_EN
    .stall_i    (stall_i),
`endif
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .data_addr_o(data_addr_o),
    .kern_addr_o(kern_addr_o),
    .bias_addr_o(bias_addr_o),
    .acc_clr_o  (acc_clr_o),
    .mac_valid_o(mac_valid_o),
    .bias_sel_o (bias_sel_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  // Event kinds: 0 rd_en, 1 mac_valid, 2 acc_clr, 3 bias_sel, 4 wr_en, 5 done
  ev_t   evq [6][$];
  string kname [6] = '{"rd_en", "mac_valid", "acc_clr", "bias_sel", "wr_en", "done"};

  int n_checks = 0;
  int n_pass   = 0;
  int free_cyc = 0;
  int busy_lo  = 1;
  int busy_hi  = 0;
  int zero_cyc = -1;

  function automatic void push(input int k, input int c, input int a, input int b);
    ev_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    evq[k].push_back(e);
  endfunction

  // Layer-level model: an accepted start at cycle c schedules every strobe of the layer.
  function automatic void model_step(input int c, input bit r, input bit s);
    int base;
    if (r) begin
      for (int k = 0; k < 6; k++)
        while (evq[k].size() > 0 && evq[k][evq[k].size()-1].cyc > c)
          void'(evq[k].pop_back());
      if (busy_hi > c) busy_hi = c;
      free_cyc = c + 1;
      zero_cyc = c + 1;
    end else if (s && c >= free_cyc) begin
      for (int n = 0; n < NEURONS; n++) begin
        base = c + 1 + n * P;
        push(2, base, 0, 0);
        for (int i = 0; i < N_IN; i++) begin
          push(0, base + i, i, n * N_IN + i);
          push(1, base + i + L, 0, 0);
        end
        push(3, base + N_IN + L, n, 0);
        push(4, base + N_IN + L + 1, n, 0);
      end
      push(5, c + NEURONS * P + 1, 0, 0);
      busy_lo  = c + 1;
      busy_hi  = c + NEURONS * P;
      free_cyc = c + NEURONS * P + 2;
    end
  endfunction

  task automatic drive(input bit r, input bit s);
    rst     = r;
    start_i = s;
    model_step(cyc, r, s);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard once per cycle.
  initial begin
    logic stb [6];
    int   aa  [6];
    int   bb  [6];
    ev_t  e;
    logic exp_busy;
    forever begin
      @(negedge clk);
      stb = '{rd_en_o, mac_valid_o, acc_clr_o, bias_sel_o, wr_en_o, done_o};
      aa  = '{int'(data_addr_o), 0, 0, int'(bias_addr_o), int'(wr_addr_o), 0};
      bb  = '{int'(kern_addr_o), 0, 0, 0, 0, 0};
      for (int k = 0; k < 6; k++) begin
        while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
          e = evq[k].pop_front();
          n_checks++;
          $display("FAIL %s stale event cyc=%0d: strobe never seen, required at cyc %0d",
                   kname[k], cyc, e.cyc);
        end
        if (evq[k].size() > 0 && evq[k][0].cyc == cyc) begin
          e = evq[k].pop_front();
          n_checks++;
          if (stb[k] !== 1'b1 || aa[k] != e.a || bb[k] != e.b)
            $display("FAIL %s cyc=%0d got strobe=%b a=%0d b=%0d, required strobe=1 a=%0d b=%0d",
                     kname[k], cyc, stb[k], aa[k], bb[k], e.a, e.b);
          else
            n_pass++;
        end else if (stb[k] !== 1'b0) begin
          n_checks++;
          $display("FAIL %s cyc=%0d got strobe=%b, required 0 (no event scheduled)",
                   kname[k], cyc, stb[k]);
        end
      end
      exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
      n_checks++;
      if (busy_o !== exp_busy)
        $display("FAIL busy cyc=%0d got %b required %b", cyc, busy_o, exp_busy);
      else
        n_pass++;
      if (cyc == zero_cyc) begin
        n_checks++;
        if ({busy_o, done_o, rd_en_o, acc_clr_o, mac_valid_o, bias_sel_o, wr_en_o,
             data_addr_o, kern_addr_o, bias_addr_o, wr_addr_o} !== '0)
          $display("FAIL reset_zero cyc=%0d got rd=%b mac=%b wr=%b busy=%b daddr=%0d kaddr=%0d baddr=%0d waddr=%0d required all 0",
                   cyc, rd_en_o, mac_valid_o, wr_en_o, busy_o, data_addr_o, kern_addr_o,
                   bias_addr_o, wr_addr_o);
        else
          n_pass++;
      end
    end
  end

  initial begin
    int guard;
    rst     = 1'b1;
    start_i = 1'b0;
`ifdef DENSE_SEQ_CTRL_STALL_EN
    stall_i = 1'b0;
`endif
    repeat (3) drive(1'b1, 1'b0);

    // single start pulse, full layer
    drive(1'b0, 1'b1);
    repeat (30) drive(1'b0, 1'b0);

    // start held high: back-to-back layers, no re-accept while busy
    repeat (60) drive(1'b0, 1'b1);
    repeat (30) drive(1'b0, 1'b0);

    // reset ten cycles into a layer, then a fresh layer
    drive(1'b0, 1'b1);
    repeat (9) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (30) drive(1'b0, 1'b0);

    // randomized starts with occasional mid-layer resets
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0);

    guard = 0;
    while (cyc < free_cyc + 3 && guard < 200) begin
      drive(1'b0, 1'b0);
      guard++;
    end
    repeat (5) drive(1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (evq[k].size() != 0)
        $display("FAIL %s_pending got %0d outstanding events required 0", kname[k], evq[k].size());
      else
        n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
